// File: rtl/mdu_ctrl.sv
// mdu_ctrl: HI/LO multiply-divide unit controller for a 5-stage MIPS-style pipeline.
// MULT/MULTU run through a MUL_LAT-cycle multiply state. DIV/DIVU run a 32-step
// restoring divider on operand magnitudes. MTHI/MTLO write HI/LO directly.
// Results sit in DONE until the pipeline is free (ext_stall=0), and are then
// committed to HI/LO.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   op_validE, op_typeE HI/LO-class op in E stage and its type
//   srcaE, srcbE        rs/rt operands
//   ext_stall           stall from other pipeline sources
//   flush_exceptionM    exception flush, cancels the E-stage op
//   mult_stallE         stall request while a multiply is in flight
//   div_stallE          stall request while a divide is in flight
//   hi_o, lo_o          architectural HI/LO
//   busy                FSM not idle
//
// state | meaning
// IDLE  | waiting for an op; MTHI/MTLO are handled here
// MUL   | multiply pipeline, cnt counts down from MUL_LAT-1
// DIV   | one quotient bit per cycle, cnt counts down from 31
// DONE  | result held, committed to HI/LO once ext_stall is low
module mdu_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_validE,
  input  logic [2:0]  op_typeE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        ext_stall,
  input  logic        flush_exceptionM,
  output logic        mult_stallE,
  output logic        div_stallE,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // opa holds the multiplicand, or the dividend magnitude shifting into the quotient
  logic [31:0] opa_q, opa_d;
  // opb holds the multiplier, or the divisor magnitude
  logic [31:0] opb_q, opb_d;
  logic [31:0] rem_q, rem_d;
  logic        sgn_q, sgn_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] res_q, res_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        can_issue, issue_mul, issue_div, mt_write;
  logic [31:0] abs_a, abs_b;
  logic [63:0] mul_a, mul_b, prod;
  logic [32:0] trial;
  logic [31:0] rem_next, quo_next, rem_fix, quo_fix;

  // rst gating keeps stalls and issue quiet during the cycle reset is applied
  assign can_issue = rst && (state_q == S_IDLE) && op_validE && !flush_exceptionM;
  assign issue_mul = can_issue && ((op_typeE == OP_MULT) || (op_typeE == OP_MULTU));
  assign issue_div = can_issue && ((op_typeE == OP_DIV) || (op_typeE == OP_DIVU));
  assign mt_write  = can_issue && !ext_stall &&
                     ((op_typeE == OP_MTHI) || (op_typeE == OP_MTLO));

  assign mult_stallE = issue_mul || (rst && (state_q == S_MUL));
  assign div_stallE  = issue_div || (rst && (state_q == S_DIV));
  assign busy        = rst && (state_q != S_IDLE);
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

  always_comb begin
    abs_a = (op_typeE == OP_DIV && srcaE[31]) ? -srcaE : srcaE;
    abs_b = (op_typeE == OP_DIV && srcbE[31]) ? -srcbE : srcbE;

    // Low 64 bits of a sign/zero-extended product are exact for both signednesses
    mul_a = {{32{sgn_q & opa_q[31]}}, opa_q};
    mul_b = {{32{sgn_q & opb_q[31]}}, opb_q};
    prod  = mul_a * mul_b;

    // Restoring step; partial remainder stays below the divisor so bit 32 is the borrow.
    // With a zero divisor every step succeeds: quotient all ones, remainder = dividend.
    trial = {rem_q, opa_q[31]} - {1'b0, opb_q};
    if (!trial[32]) begin
      rem_next = trial[31:0];
      quo_next = {opa_q[30:0], 1'b1};
    end else begin
      rem_next = {rem_q[30:0], opa_q[31]};
      quo_next = {opa_q[30:0], 1'b0};
    end
    quo_fix = neg_quo_q ? -quo_next : quo_next;
    rem_fix = neg_rem_q ? -rem_next : rem_next;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    rem_d     = rem_q;
    sgn_d     = sgn_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    res_d     = res_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE: begin
        if (issue_mul) begin
          opa_d   = srcaE;
          opb_d   = srcbE;
          sgn_d   = (op_typeE == OP_MULT);
          cnt_d   = 5'(MUL_LAT - 1);
          state_d = S_MUL;
        end else if (issue_div) begin
          opa_d     = abs_a;
          opb_d     = abs_b;
          rem_d     = 32'd0;
          neg_quo_d = (op_typeE == OP_DIV) && (srcaE[31] ^ srcbE[31]);
          neg_rem_d = (op_typeE == OP_DIV) && srcaE[31];
          cnt_d     = 5'd31;
          state_d   = S_DIV;
        end else if (mt_write) begin
          if (op_typeE == OP_MTHI) hi_d = srcaE;
          else                     lo_d = srcaE;
        end
      end
      S_MUL: begin
        if (cnt_q == 5'd0) begin
          res_d   = prod;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_DIV: begin
        opa_d = quo_next;
        rem_d = rem_next;
        if (cnt_q == 5'd0) begin
          res_d   = {rem_fix, quo_fix};
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_DONE: begin
        if (!ext_stall) begin
          hi_d    = res_q[63:32];
          lo_d    = res_q[31:0];
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush_exceptionM) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      opa_q     <= 32'd0;
      opb_q     <= 32'd0;
      rem_q     <= 32'd0;
      sgn_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_q     <= 64'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      rem_q     <= rem_d;
      sgn_q     <= sgn_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      res_q     <= res_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule
